// File: rtl/reg_port_arbiter_pkg.sv
// Shared definitions for the register-port arbiter: FSM state encodings,
// access-owner IDs, register-file width defaults and the starvation counter
// saturating-increment helper.
package reg_port_arbiter_pkg;

  localparam int REG_ADDR_W = 8;  // register index width
  localparam int REG_DATA_W = 8;  // register data width
  localparam int STARVE_W   = 4;  // starvation counter width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I2C = 1'b0,  // m0
    OWN_INT = 1'b1   // m1
  } owner_e;

  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/reg_port_arbiter.sv
// Purpose : shares one register-file port between the I2C slave (m0) and an
//           internal requester (m1); m0 has priority, m1 ages in after
//           STARVE_LIMIT lost arbitrations and is blocked while lock is high.
// Latency : gnt + strobes 1 cycle after the IDLE sample; rvalid REG_RD_LAT
//           cycles after gnt; a write occupies the port for 2 cycles.
// Backpr. : requesters hold req until gnt; one access in flight at a time.
// Ports   : clk, rst (async, active high); lock; m0_/m1_ req/we/addr/wdata in,
//           gnt/rvalid out; shared rdata; register port write/read_1/index_1/
//           data_out out and data_in in.
module reg_port_arbiter
  import reg_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = REG_ADDR_W,
  parameter int DATA_W       = REG_DATA_W,
  parameter int REG_RD_LAT   = 1,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lock,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              write,
  output logic              read_1,
  output logic [ADDR_W-1:0] index_1,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in
);

  // RDWAIT lasts REG_RD_LAT-1 cycles; the counter is loaded with the number of
  // cycles remaining after the first one.
  localparam int WAIT_W = $clog2(REG_RD_LAT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    WAIT_W'((REG_RD_LAT >= 2) ? (REG_RD_LAT - 2) : 0);
  localparam logic [STARVE_W-1:0] STARVE_THR = STARVE_W'(STARVE_LIMIT);

  state_e              state_q;
  owner_e              owner_q;
  logic                we_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic                m0_gnt_q, m1_gnt_q, m0_rvalid_q, m1_rvalid_q;
  logic                write_q, read_q;
  logic [ADDR_W-1:0]   index_q;
  logic [DATA_W-1:0]   dout_q, rdata_q;

  logic                m1_win, m0_win;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Arbitration is only meaningful in IDLE; outside it both wins are forced
  // low, which also freezes the starvation counter.
  always_comb begin
    m1_win    = (state_q == ST_IDLE) && m1_req && !lock &&
                (!m0_req || (starve_q >= STARVE_THR));
    m0_win    = (state_q == ST_IDLE) && m0_req && !m1_win;
    sel_we    = m1_win ? m1_we    : m0_we;
    sel_addr  = m1_win ? m1_addr  : m0_addr;
    sel_wdata = m1_win ? m1_wdata : m0_wdata;
    starve_d  = starve_q;
    if (m1_win) begin
      starve_d = '0;
    end else if (m0_win && m1_req && !lock) begin
      starve_d = starve_inc(starve_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_I2C;
      we_q        <= 1'b0;
      wait_q      <= '0;
      starve_q    <= '0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      index_q     <= '0;
      dout_q      <= '0;
      rdata_q     <= '0;
    end else begin
      // Grants, strobes and rvalid are single-cycle pulses.
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      starve_q    <= starve_d;
      case (state_q)
        ST_IDLE: begin
          if (m1_win || m0_win) begin
            owner_q  <= m1_win ? OWN_INT : OWN_I2C;
            we_q     <= sel_we;
            index_q  <= sel_addr;
            dout_q   <= sel_wdata;
            write_q  <= sel_we;
            read_q   <= !sel_we;
            m0_gnt_q <= m0_win;
            m1_gnt_q <= m1_win;
            state_q  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (we_q) begin
            state_q <= ST_IDLE;
          end else if (REG_RD_LAT == 1) begin
            // Single-cycle read: data_in is already valid at the end of ACCESS.
            rdata_q     <= data_in;
            m0_rvalid_q <= (owner_q == OWN_I2C);
            m1_rvalid_q <= (owner_q == OWN_INT);
            state_q     <= ST_IDLE;
          end else begin
            wait_q  <= WAIT_LOAD;
            state_q <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          if (wait_q == '0) begin
            rdata_q     <= data_in;
            m0_rvalid_q <= (owner_q == OWN_I2C);
            m1_rvalid_q <= (owner_q == OWN_INT);
            state_q     <= ST_IDLE;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign write     = write_q;
  assign read_1    = read_q;
  assign index_1   = index_q;
  assign data_out  = dout_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: a transaction-level model (port-busy countdown,
// pending-read countdown, lost-arbitration tally) predicts every output each
// cycle for a REG_RD_LAT=1 instance; a second REG_RD_LAT=3 instance covers
// reset during a read wait and back-to-back read spacing.
module tb_reg_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance, REG_RD_LAT = 1 ----------------
  logic       lock, m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, write, read_1;
  logic [7:0] rdata, index_1, data_out, data_in;

  reg_port_arbiter #(.ADDR_W(8), .DATA_W(8), .REG_RD_LAT(1), .STARVE_LIMIT(15)) u_dut (
    .clk(clk), .rst(rst), .lock(lock),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .write(write), .read_1(read_1), .index_1(index_1),
    .data_out(data_out), .data_in(data_in)
  );

  function automatic logic [7:0] base_val(input logic [7:0] a);
    return (a == 8'h48) ? 8'h03 : (a ^ 8'hC3);
  endfunction

  // Register file: base pattern overlaid by whatever the DUT writes.
  logic [7:0] ovl [256];
  bit         ovl_vld [256];
  always @(posedge clk) if (write) begin
    ovl[index_1]     <= data_out;
    ovl_vld[index_1] <= 1'b1;
  end
  assign data_in = ovl_vld[index_1] ? ovl[index_1] : base_val(index_1);

  // ---------------- second instance, REG_RD_LAT = 3 ----------------
  logic       m0_req3, m0_we3;
  logic [7:0] m0_addr3;
  logic       m0_gnt3, m1_gnt3, m0_rvalid3, m1_rvalid3, write3, read3;
  logic [7:0] rdata3, index3, dout3, data_in3, p1, p2;

  reg_port_arbiter #(.ADDR_W(8), .DATA_W(8), .REG_RD_LAT(3), .STARVE_LIMIT(15)) u_dut3 (
    .clk(clk), .rst(rst), .lock(1'b0),
    .m0_req(m0_req3), .m0_we(m0_we3), .m0_addr(m0_addr3), .m0_wdata(8'h00),
    .m0_gnt(m0_gnt3), .m0_rvalid(m0_rvalid3),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr(8'h00), .m1_wdata(8'h00),
    .m1_gnt(m1_gnt3), .m1_rvalid(m1_rvalid3),
    .rdata(rdata3), .write(write3), .read_1(read3), .index_1(index3),
    .data_out(dout3), .data_in(data_in3)
  );

  function automatic logic [7:0] base3(input logic [7:0] a);
    return (a == 8'h41) ? 8'h11 : (a == 8'h42) ? 8'h22 : 8'hEE;
  endfunction

  // Data valid two cycles after the index is presented (3 edges after strobe rise).
  always @(posedge clk) begin
    p1 <= base3(index3);
    p2 <= p1;
  end
  assign data_in3 = p2;

  // ---------------- model ----------------
  localparam int LAT = 1;
  logic [7:0] ref_ovl [256];
  bit         ref_vld [256];
  int         busy, rv_cnt, starve;
  bit         rv_own;
  logic [7:0] rv_addr;
  logic       e_gnt0, e_gnt1, e_rv0, e_rv1, e_wr, e_rd;
  logic [7:0] e_rdata, e_idx, e_dout;

  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_wr = 0; e_rd = 0;
    e_rdata = 8'h00; e_idx = 8'h00; e_dout = 8'h00;
    busy = 0; rv_cnt = 0; starve = 0; rv_own = 0; rv_addr = 8'h00;
  endtask

  task automatic model_grant(input bit who, input logic we, input logic [7:0] a,
                             input logic [7:0] d);
    if (who) e_gnt1 = 1; else e_gnt0 = 1;
    e_idx  = a;
    e_dout = d;
    if (we) begin
      e_wr = 1;
      ref_ovl[a] = d;
      ref_vld[a] = 1;
      busy = 1;
    end else begin
      e_rd = 1;
      busy = LAT;
      rv_cnt = LAT;
      rv_own = who;
      rv_addr = a;
    end
  endtask

  // One clock edge of the model, using the inputs present before the edge.
  task automatic model_edge();
    bit win0, win1;
    e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_wr = 0; e_rd = 0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        if (rv_own) e_rv1 = 1; else e_rv0 = 1;
        e_rdata = ref_vld[rv_addr] ? ref_ovl[rv_addr] : base_val(rv_addr);
      end
    end
    if (busy > 0) begin
      busy--;
    end else begin
      win1 = m1_req && !lock && (!m0_req || starve >= 15);
      win0 = !win1 && m0_req;
      if (win1) begin
        model_grant(1'b1, m1_we, m1_addr, m1_wdata);
        starve = 0;
      end else if (win0) begin
        model_grant(1'b0, m0_we, m0_addr, m0_wdata);
        if (m1_req && !lock && starve < 15) starve++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("m0_gnt", m0_gnt, e_gnt0);
    chk("m1_gnt", m1_gnt, e_gnt1);
    chk("m0_rvalid", m0_rvalid, e_rv0);
    chk("m1_rvalid", m1_rvalid, e_rv1);
    chk("write", write, e_wr);
    chk("read_1", read_1, e_rd);
    chk("index_1", index_1, e_idx);
    chk("data_out", data_out, e_dout);
    chk("rdata", rdata, e_rdata);
  endtask

  task automatic cycle_step();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    cycle_step();
    cycle_step();
    rst = 1'b0;
  endtask

  task automatic chk_dut3_zero(input string tag);
    chk({tag, "_gnt0"}, m0_gnt3, 0);
    chk({tag, "_gnt1"}, m1_gnt3, 0);
    chk({tag, "_rv0"}, m0_rvalid3, 0);
    chk({tag, "_rv1"}, m1_rvalid3, 0);
    chk({tag, "_wr"}, write3, 0);
    chk({tag, "_rd"}, read3, 0);
    chk({tag, "_idx"}, index3, 0);
    chk({tag, "_dout"}, dout3, 0);
    chk({tag, "_rdata"}, rdata3, 0);
  endtask

  // ---------------- random masters ----------------
  int p_req0, p_req1, p_wd, p_lock, force_we;

  task automatic drive_masters();
    if (m0_req && !e_gnt0) begin
      if ($urandom_range(99) < p_wd) m0_req = 0;
    end else if ($urandom_range(99) < p_req0) begin
      m0_req   = 1;
      m0_we    = (force_we < 0) ? 1'($urandom_range(1)) : force_we[0];
      m0_addr  = 8'h40 + 8'($urandom_range(15));
      m0_wdata = 8'($urandom);
    end else begin
      m0_req = 0;
    end
    if (m1_req && !e_gnt1) begin
      if ($urandom_range(99) < p_wd) m1_req = 0;
    end else if ($urandom_range(99) < p_req1) begin
      m1_req   = 1;
      m1_we    = (force_we < 0) ? 1'($urandom_range(1)) : force_we[0];
      m1_addr  = 8'h40 + 8'($urandom_range(15));
      m1_wdata = 8'($urandom);
    end else begin
      m1_req = 0;
    end
    if ($urandom_range(99) < p_lock) lock = !lock;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n0, n1, n0_before, n0_after, cnt, rv_seen, t_rv [2];
    logic [7:0] d_rv [2];
    bit got;
    lock = 0; m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    m0_req3 = 0; m0_we3 = 0; m0_addr3 = 0;
    p_req0 = 0; p_req1 = 0; p_wd = 0; p_lock = 0; force_we = -1;

    #1;
    do_reset();
    chk("reset_gnt0", m0_gnt, 0);
    chk("reset_index", index_1, 0);
    chk("reset_rdata", rdata, 0);

    // 1: lone m0 write 0x40 <= 0xA5
    m0_req = 1; m0_we = 1; m0_addr = 8'h40; m0_wdata = 8'hA5;
    cycle_step();
    chk("t1_gnt", m0_gnt, 1);
    chk("t1_write", write, 1);
    chk("t1_index", index_1, 8'h40);
    chk("t1_dout", data_out, 8'hA5);
    m0_req = 0;
    cycle_step();
    chk("t1_write_single", write, 0);

    // 2: m1 read of 0x48, register returns 0x03, rvalid one cycle after gnt
    m1_req = 1; m1_we = 0; m1_addr = 8'h48;
    cycle_step();
    chk("t2_gnt", m1_gnt, 1);
    chk("t2_read", read_1, 1);
    m1_req = 0;
    cycle_step();
    chk("t2_rvalid", m1_rvalid, 1);
    chk("t2_rdata", rdata, 8'h03);
    cycle_step();

    // 3: both request continuously for 40 cycles
    do_reset();
    p_req0 = 100; p_req1 = 100; p_wd = 0; p_lock = 0; force_we = 1; lock = 0;
    drive_masters();
    n0 = 0; n1 = 0; n0_before = -1; n0_after = 0;
    for (int i = 0; i < 40; i++) begin
      cycle_step();
      if (m1_gnt) begin
        n1++;
        if (n1 == 1) n0_before = n0;
      end
      if (m0_gnt) begin
        n0++;
        if (n1 > 0) n0_after++;
      end
      drive_masters();
    end
    m0_req = 0; m1_req = 0;
    chk("t3_m0_before_m1", n0_before, 15);
    chk("t3_m1_grants", n1, 1);
    chk("t3_m0_after_m1", n0_after, 4);
    cycle_step();
    cycle_step();

    // 4: lock blocks a lone m1 request
    lock = 1; m1_req = 1; m1_we = 0; m1_addr = 8'h4A;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle_step();
      if (m1_gnt || write || read_1) cnt++;
    end
    chk("t4_locked_activity", cnt, 0);
    lock = 0;
    got = 0;
    for (int i = 0; i < 2 && !got; i++) begin
      cycle_step();
      if (m1_gnt) begin
        got = 1;
        m1_req = 0;
      end
    end
    chk("t4_gnt_after_unlock", got, 1);
    m1_req = 0;
    repeat (3) cycle_step();

    // Random traffic with lock toggling and withdrawn requests
    p_req0 = 40; p_req1 = 40; p_wd = 5; p_lock = 5; force_we = -1;
    for (int i = 0; i < 3000; i++) begin
      cycle_step();
      drive_masters();
    end
    m0_req = 0; m1_req = 0; lock = 0;
    repeat (4) cycle_step();

    // 5: reset during the read wait of the REG_RD_LAT=3 instance
    m0_req3 = 1; m0_we3 = 0; m0_addr3 = 8'h41;
    cycle_step();
    chk("t5_gnt", m0_gnt3, 1);
    chk("t5_read", read3, 1);
    m0_req3 = 0;
    cycle_step();
    rst = 1;
    #1;
    model_reset();
    chk_dut3_zero("t5_async");
    cycle_step();
    chk_dut3_zero("t5_edge");
    rst = 0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle_step();
      if (m0_rvalid3) cnt++;
    end
    chk("t5_no_rvalid", cnt, 0);

    // 6: back-to-back reads 0x41, 0x42 on the REG_RD_LAT=3 instance
    m0_req3 = 1; m0_we3 = 0; m0_addr3 = 8'h41;
    rv_seen = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle_step();
      if (m0_gnt3) begin
        if (m0_addr3 == 8'h41) m0_addr3 = 8'h42;
        else m0_req3 = 0;
      end
      if (m0_rvalid3) begin
        if (rv_seen < 2) begin
          t_rv[rv_seen] = i;
          d_rv[rv_seen] = rdata3;
        end
        rv_seen++;
      end
    end
    m0_req3 = 0;
    chk("t6_rvalid_count", rv_seen, 2);
    if (rv_seen >= 2) begin
      chk("t6_first_latency", t_rv[0], 4);
      chk("t6_spacing", t_rv[1] - t_rv[0], 4);
      chk("t6_data_41", d_rv[0], 8'h11);
      chk("t6_data_42", d_rv[1], 8'h22);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
